// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared types and constants for the ASCON permutation control
package ascon_pack;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } type_perm_fsm;

    localparam logic [3:0] LAST_ROUND    = 4'd11;
    localparam int         NB_ROUNDS_MAX = 12;

    // p^n always ends on LAST_ROUND, so it starts NB_ROUNDS_MAX-n rounds in.
    function automatic logic [3:0] first_round(input int nb_rounds);
        return 4'(NB_ROUNDS_MAX - nb_rounds);
    endfunction

endpackage

// File: rtl/round_counter.sv
// rtl/round_counter.sv - loadable round-index counter that saturates at LAST_ROUND
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       inc_i,
    output logic [3:0] count_o,
    output logic       last_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i && (count_q != LAST_ROUND)) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == LAST_ROUND);

endmodule

// File: rtl/permutation_sequencer.sv
// rtl/permutation_sequencer.sv - sequences the ASCON datapath through p^a or p^b rounds
module permutation_sequencer
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 8
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       sel_pb_i,
    input  logic       stall_i,
    output logic       ready_o,
    output logic       init_p_o,
    output logic       enable_p_o,
    output logic [3:0] round_p_o,
    output logic       done_o,
    output logic       state_valid_o
);

    if ((ROUNDS_A < 1) || (ROUNDS_A > NB_ROUNDS_MAX) ||
        (ROUNDS_B < 1) || (ROUNDS_B > NB_ROUNDS_MAX)) begin : g_bad_rounds
        $fatal(1, "permutation_sequencer: ROUNDS_A/ROUNDS_B must be in 1..12");
    end

    type_perm_fsm state_q;
    type_perm_fsm state_d;
    logic         first_q;
    logic         first_d;
    logic         valid_q;
    logic         valid_d;

    logic         cnt_load;
    logic [3:0]   cnt_load_val;
    logic         cnt_inc;
    logic [3:0]   cnt_value;
    logic         cnt_last;

    round_counter u_round_counter (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .inc_i      (cnt_inc),
        .count_o    (cnt_value),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        valid_d      = valid_q;
        cnt_load     = 1'b0;
        cnt_load_val = first_round(ROUNDS_A);
        cnt_inc      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = sel_pb_i ? first_round(ROUNDS_B) : first_round(ROUNDS_A);
                    first_d      = 1'b1;
                    valid_d      = 1'b0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                // A stalled cycle freezes counter, first flag and state together.
                if (!stall_i) begin
                    first_d = 1'b0;
                    if (cnt_last) begin
                        state_d = DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            valid_q <= valid_d;
        end
    end

    assign ready_o       = (state_q == IDLE);
    assign init_p_o      = (state_q == RUN) && first_q && !stall_i;
    assign enable_p_o    = (state_q == RUN) && !stall_i;
    assign round_p_o     = cnt_value;
    assign done_o        = (state_q == DONE);
    assign state_valid_o = valid_q;

endmodule
